// File: rtl/shift_register_engine.sv
// W-bit register with synchronous clear/preset, parallel load and a
// one-bit-per-clock shift/rotate engine behind a start/busy/done handshake.

module shift_register_engine_bit #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic pre,
    input  logic ld,
    input  logic step_r,
    input  logic step_l,
    input  logic d,
    input  logic from_left,
    input  logic from_right,
    output logic q
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       q <= RST_BIT;
        else if (clr)    q <= 1'b0;
        else if (pre)    q <= 1'b1;
        else if (ld)     q <= d;
        else if (step_r) q <= from_left;
        else if (step_l) q <= from_right;
    end
endmodule

module shift_register_engine #(
    parameter int             W           = 8,
    parameter logic [W-1:0]   RESET_VALUE = '0,
    localparam int            CW          = $clog2(W+1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          preset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [CW-1:0] amount,
    input  logic [W-1:0]  d,
    input  logic          sin,
    output logic [W-1:0]  q,
    output logic          sout,
    output logic          busy,
    output logic          done
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [1:0]    OP_LOAD = 2'b00;
    localparam logic [1:0]    OP_SHL  = 2'b10;
    localparam logic [1:0]    OP_ROTR = 2'b11;
    localparam logic [CW-1:0] W_CNT   = CW'(W);

    state_t        state;
    logic [CW-1:0] rem;
    logic [1:0]    op_r;

    logic          accept, shifting, load_en, step_r, step_l, msb_fill;
    logic [CW-1:0] amt_sat;

    always_comb begin
        accept   = start & ~clear & ~preset & (state == IDLE);
        shifting = (state == SHIFT) & ~clear & ~preset;
        load_en  = accept & (op == OP_LOAD);
        // SHR and ROTR both move toward the LSB; only the MSB fill differs
        step_r   = shifting & (op_r != OP_SHL);
        step_l   = shifting & (op_r == OP_SHL);
        msb_fill = (op_r == OP_ROTR) ? q[0] : sin;
        amt_sat  = (amount > W_CNT) ? W_CNT : amount;
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic from_left, from_right;
        if (i == W-1) begin : g_msb
            assign from_left = msb_fill;
        end else begin : g_upper
            assign from_left = q[i+1];
        end
        if (i == 0) begin : g_lsb
            assign from_right = sin;
        end else begin : g_lower
            assign from_right = q[i-1];
        end
        shift_register_engine_bit #(.RST_BIT(RESET_VALUE[i])) u_bit (
            .clock      (clock),
            .reset      (reset),
            .clr        (clear),
            .pre        (preset),
            .ld         (load_en),
            .step_r     (step_r),
            .step_l     (step_l),
            .d          (d[i]),
            .from_left  (from_left),
            .from_right (from_right),
            .q          (q[i])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
            op_r  <= OP_LOAD;
            busy  <= 1'b0;
            done  <= 1'b0;
            sout  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear || preset) begin
                // abort any shift in flight; sout keeps its last value
                state <= IDLE;
                rem   <= '0;
                busy  <= 1'b0;
            end else if (accept) begin
                if (op == OP_LOAD || amt_sat == '0) begin
                    done <= 1'b1;
                end else begin
                    state <= SHIFT;
                    rem   <= amt_sat;
                    op_r  <= op;
                    busy  <= 1'b1;
                end
            end else if (state == SHIFT) begin
                sout <= (op_r == OP_SHL) ? q[W-1] : q[0];
                rem  <= rem - 1'b1;
                if (rem == CW'(1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_shift_register_engine.sv
// Directed test-plan steps followed by random traffic, all checked against
// an arithmetic reference model of the register.

module tb_shift_register_engine;
    localparam int W  = 8;
    localparam int CW = $clog2(W+1);
    localparam logic [W-1:0] RV = 8'hA5;

    logic          clock = 1'b0;
    logic          reset, clear, preset, start, sin;
    logic [1:0]    op;
    logic [CW-1:0] amount;
    logic [W-1:0]  d;
    logic [W-1:0]  q;
    logic          sout, busy, done;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [W-1:0] mq;
    logic         msout, mdone;
    int           mrem;
    logic [1:0]   mop;

    shift_register_engine #(.W(W), .RESET_VALUE(RV)) dut (
        .clock(clock), .reset(reset), .clear(clear), .preset(preset),
        .start(start), .op(op), .amount(amount), .d(d), .sin(sin),
        .q(q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq = RV; msout = 1'b0; mdone = 1'b0; mrem = 0; mop = 2'b00;
    endtask

    task automatic model_edge();
        int n;
        logic [W-1:0] old;
        old = mq;
        if (clear) begin
            mq = '0; mrem = 0; mdone = 1'b0;
        end else if (preset) begin
            mq = '1; mrem = 0; mdone = 1'b0;
        end else if (mrem == 0 && start) begin
            if (op == 2'b00) begin
                mq = d; mdone = 1'b1;
            end else begin
                n = (int'(amount) > W) ? W : int'(amount);
                if (n == 0) mdone = 1'b1;
                else begin mrem = n; mop = op; mdone = 1'b0; end
            end
        end else if (mrem > 0) begin
            case (mop)
                2'b01: begin mq = (old >> 1) | (W'(sin) << (W-1));   msout = old[0];   end
                2'b10: begin mq = (old << 1) | W'(sin);              msout = old[W-1]; end
                default: begin mq = (old >> 1) | (W'(old[0]) << (W-1)); msout = old[0]; end
            endcase
            mrem--;
            mdone = (mrem == 0);
        end else begin
            mdone = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("q",    q,    mq);
        chk("busy", W'(busy), W'(mrem != 0));
        chk("done", W'(done), W'(mdone));
        chk("sout", W'(sout), W'(msout));
        chk("busy_done_excl", W'(busy & done), '0);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; clear = 0; preset = 0; start = 0; sin = 0;
        op = 2'b00; amount = '0; d = '0;
        model_reset();
        #12;
        check_all();
        chk("rst_q", q, 8'hA5);
        reset = 1'b0;

        // LOAD 3C
        start = 1; op = 2'b00; d = 8'h3C; amount = 4'd7;
        cyc();
        chk("load_q", q, 8'h3C);
        chk("load_done", W'(done), 1);
        start = 0;
        cyc();

        // SHR by 3 with sin=1
        start = 1; op = 2'b01; amount = 3; sin = 1;
        cyc();
        chk("shr_busy", W'(busy), 1);
        start = 0;
        cyc(); chk("shr_s1", q, 8'h9E);
        cyc(); chk("shr_s2", q, 8'hCF);
        cyc(); chk("shr_s3", q, 8'hE7);
        chk("shr_sout", W'(sout), 1);
        chk("shr_done", W'(done), 1);
        cyc();

        // LOAD 81 then back-to-back ROTR by 12 (saturates to 8), start pokes ignored
        start = 1; op = 2'b00; d = 8'h81;
        cyc();
        op = 2'b11; amount = 12; d = 8'h00;
        cyc();
        for (int i = 0; i < 8; i++) begin
            start = 1'($urandom); op = 2'($urandom); amount = 4'($urandom); d = 8'($urandom);
            cyc();
        end
        chk("rotr_q", q, 8'h81);
        chk("rotr_done", W'(done), 1);
        start = 0;
        cyc();

        // SHL by 4 aborted by clear on the 2nd step edge, with a colliding start
        start = 1; op = 2'b00; d = 8'hFF;
        cyc();
        op = 2'b10; amount = 4; sin = 0;
        cyc();
        start = 0;
        cyc(); chk("shl_s1", q, 8'hFE);
        clear = 1; start = 1; op = 2'b00; d = 8'h33;
        cyc();
        chk("abort_q", q, 8'h00);
        chk("abort_busy", W'(busy), 0);
        clear = 0; start = 0;
        cyc();
        chk("abort_nodone", W'(done), 0);

        // clear+preset, preset alone, zero-amount shift
        start = 1; op = 2'b00; d = 8'h5A;
        cyc();
        start = 0; clear = 1; preset = 1;
        cyc(); chk("clr_wins", q, 8'h00);
        clear = 0;
        cyc(); chk("preset", q, 8'hFF);
        preset = 0; start = 1; op = 2'b10; amount = 0;
        cyc();
        chk("zero_q", q, 8'hFF);
        chk("zero_done", W'(done), 1);
        start = 0;

        // async reset mid-SHR
        start = 1; op = 2'b01; amount = 5; sin = 0;
        cyc();
        start = 0;
        cyc(); cyc();
        #2 reset = 1;
        #1;
        model_reset();
        chk("areset_q", q, 8'hA5);
        chk("areset_busy", W'(busy), 0);
        check_all();
        reset = 0;
        start = 1; op = 2'b00; d = 8'h77;
        cyc();
        chk("post_reset_load", q, 8'h77);
        start = 0;
        cyc();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            start  = ($urandom_range(0, 1) == 1);
            op     = 2'($urandom);
            amount = CW'($urandom_range(0, 15));
            d      = W'($urandom);
            sin    = 1'($urandom);
            clear  = ($urandom_range(0, 19) == 0);
            preset = ($urandom_range(0, 19) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_register_engine.md
# shift_register_engine

Parametrised W-bit D-register with synchronous preset/clear and a multi-cycle shift engine. It supports parallel load, and logical or rotate shifts by a programmable amount, executed one bit per clock behind a start/busy/done handshake. It is the edge-triggered, multi-bit successor to the single-bit preset/preclear D latch. Datapath blocks use it as a serial/parallel converter or as an iterative shifter feeding multiply/divide sequencers.

## Interface
- W, 8: register width, ≥2.
- RESET_VALUE, 0: W-bit value loaded into q on reset.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear: q ← 0.
- preset  in  1  synchronous preset: q ← all ones.
- start  in  1  command strobe, sampled on the clock edge.
- op  in  2  command: 00 LOAD, 01 SHR, 10 SHL, 11 ROTR.
- amount  in  CW = $clog2(W+1)  shift count, sampled with start.
- d  in  W  parallel load data.
- sin  in  1  serial input: enters at MSB on SHR, at LSB on SHL.
- q  out  W  register contents.
- sout  out  1  registered copy of the last bit shifted or rotated out.
- busy  out  1  high while a shift is in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- One clock; reset is asynchronous and active-high.
- Reset values: q=RESET_VALUE, sout=0, busy=0, done=0, FSM=IDLE, remaining-count=0.
- FSM states:
  - IDLE: busy=0.
  - SHIFT: busy=1, holds remaining count rem.
- Priority at each edge, highest first: reset, clear, preset, command, shift step.
- clear and preset:
  - Both high: clear wins.
  - Either one in SHIFT aborts the operation: FSM→IDLE, rem→0, done stays 0, sout unchanged.
  - A start sampled on the same edge is discarded.
- start is accepted only when busy=0 and neither clear nor preset is high. While busy, start is ignored with no queuing.
- LOAD:
  - q←d on the accepting edge.
  - done=1 for the following cycle.
  - busy never rises; amount is ignored.
- SHR/SHL/ROTR with amount=0: q unchanged, done=1 next cycle, busy never rises.
- SHR/SHL/ROTR with amount=n>0:
  - Amounts above W saturate to W.
  - The accepting edge enters SHIFT with rem=n; q is not yet modified.
  - Each subsequent edge performs one 1-bit step and decrements rem.
  - The step on which rem reaches 0 returns to IDLE and raises done.
- Step definitions:
  - SHR: q←{sin, q[W-1:1]}, sout←q[0].
  - SHL: q←{q[W-2:0], sin}, sout←q[W-1].
  - ROTR: q←{q[0], q[W-1:1]}, sout←q[0].
- sin is sampled at every step edge, not latched at start.
- op, amount and d are captured at start. Later changes during SHIFT have no effect.

## Timing
- Start accepted on edge k with n>0:
  - busy is high in the n cycles following edges k…k+n-1.
  - The final q is valid after edge k+n.
  - done is high exactly one cycle, after edge k+n.
  - The earliest next accepted start is edge k+n+1, i.e. the first edge at which busy was 0.
- LOAD or n=0: done is high the cycle after the accepting edge. Back-to-back commands on consecutive edges are allowed.
- done and busy are never high in the same cycle.
- reset asserted mid-SHIFT: all outputs return to reset values immediately (asynchronously), with no done pulse.
- The register is throughput-limited to one bit per cycle. Latency equals the saturated amount plus 1 to done.

## Test plan
- Reset with RESET_VALUE=8'hA5 → q=A5, busy=0, done=0, sout=0.
  - Deassert reset, then LOAD d=3C → q=3C after 1 edge, done pulses 1 cycle, busy stays 0.
- q=3C, SHR amount=3, sin=1 → busy high for 3 cycles.
  - q sequence: 9E, CF, E7.
  - sout=1 at end; done pulses once, after the third step.
- q=81, ROTR amount=12 (saturates to 8) → 8 busy cycles, final q=81, done after edge 8.
  - start pulses during busy are ignored.
- q=FF, SHL amount=4, sin=0; clear asserted on the 2nd step edge → q=00, busy=0, no done.
  - A start on the same edge is discarded.
- clear and preset both high with q=5A → q=00.
  - preset alone → q=FF.
  - SHL amount=0 → q unchanged, done next cycle.
- reset pulsed asynchronously between edges mid-SHR → q=RESET_VALUE, busy=0 immediately.
  - The next LOAD behaves normally.
